// File: rtl/ip_hdr_pkg.sv
// Shared constants, state/mode types and beat-count helper for the IPv4 header checksum engine.
package ip_hdr_pkg;
    localparam logic [3:0] IPV4_VERSION = 4'd4;
    localparam logic [3:0] IHL_MIN      = 4'd5;
    localparam int         CSUM_HW_IDX  = 5;
    localparam int         ACC_W        = 22;

    typedef enum logic [2:0] {IDLE, FIRST, ACC, ERR, FOLD, DONE} csum_state_t;
    typedef enum logic {GENERATE, VERIFY} csum_mode_t;

    // Bus beats needed to carry an IHL-word header (64-bit bus rounds odd IHL up).
    function automatic logic [4:0] beats_for_ihl(input logic [3:0] ihl, input int data_w);
        logic [4:0] words;
        words = {1'b0, ihl};
        if (data_w == 64) return (words + 5'd1) >> 1;
        return words;
    endfunction
endpackage

// File: rtl/ones_comp_add.sv
// Registered lane adder: sums the unmasked 16-bit lanes of one beat into a wide accumulator.
module ones_comp_add
    import ip_hdr_pkg::*;
#(
    parameter int LANES = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clr,
    input  logic                i_en,
    input  logic [LANES*16-1:0] i_data,
    input  logic [LANES-1:0]    i_mask,
    output logic [ACC_W-1:0]    o_acc
);
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_beat_sum;

    // Lane 0 is the most significant halfword of the beat (big-endian bus).
    always_comb begin
        w_beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!i_mask[l])
                w_beat_sum = w_beat_sum + ACC_W'(i_data[LANES*16-1-16*l -: 16]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_acc <= '0;
        else if (i_clr)
            r_acc <= '0;
        else if (i_en)
            r_acc <= r_acc + w_beat_sum;
    end

    assign o_acc = r_acc;
endmodule

// File: rtl/ip_v4_hdr_csum_engine.sv
// IPv4 header checksum engine: generates or verifies the one's-complement header checksum
// over a streamed header of IHL 5..15 on a 32- or 64-bit bus.
module ip_v4_hdr_csum_engine
    import ip_hdr_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] d_in,
    input  logic              d_in_vld,
    output logic [15:0]       crc,
    output logic              crc_vld,
    output logic              crc_ok,
    output logic              hdr_err,
    output logic              busy
);
    localparam int LANES = DATA_W / 16;

    if (DATA_W != 32 && DATA_W != 64) begin : g_bad_width
        $error("ip_v4_hdr_csum_engine: DATA_W must be 32 or 64");
    end

    csum_state_t      r_state;
    csum_state_t      w_state_nxt;
    csum_mode_t       r_mode;
    logic [3:0]       r_ihl;
    logic [3:0]       r_cnt;
    logic [15:0]      r_fold16_p1;
    logic [15:0]      r_crc;
    logic             r_crc_vld;
    logic             r_crc_ok;
    logic             r_hdr_err;
    logic [ACC_W-1:0] w_acc_p0;
    logic [LANES-1:0] w_mask;
    logic             w_hdr_bad;
    logic             w_last;
    logic             w_acc_en;
    logic [4:0]       w_beats_total;
    logic [15:0]      w_crc_new;

    // Second fold cannot carry again: the first fold's sum is at most 0x1003E.
    function automatic logic [15:0] fold16(input logic [ACC_W-1:0] a);
        logic [16:0] s1;
        logic [15:0] s2;
        s1 = {1'b0, a[15:0]} + 17'(a[ACC_W-1:16]);
        s2 = s1[15:0] + {15'b0, s1[16]};
        return s2;
    endfunction

    assign w_hdr_bad     = (d_in[DATA_W-1 -: 4] != IPV4_VERSION) || (d_in[DATA_W-5 -: 4] < IHL_MIN);
    assign w_beats_total = beats_for_ihl(r_ihl, DATA_W);
    assign w_last        = (r_state == ACC) && ({1'b0, r_cnt} == w_beats_total - 5'd1);
    assign w_acc_en      = d_in_vld && !start &&
                           (((r_state == FIRST) && !w_hdr_bad) || (r_state == ACC));

    always_comb begin
        w_mask = '0;
        for (int l = 0; l < LANES; l++) begin
            if (r_mode == GENERATE && (int'(r_cnt) * LANES + l) == CSUM_HW_IDX)
                w_mask[l] = 1'b1;
            if (DATA_W == 64 && r_ihl[0] && w_last && l >= 2)
                w_mask[l] = 1'b1;
        end
    end

    ones_comp_add #(
        .LANES (LANES)
    ) u_acc (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (start),
        .i_en   (w_acc_en),
        .i_data (d_in),
        .i_mask (w_mask),
        .o_acc  (w_acc_p0)
    );

    // start has priority in every state: it aborts any header in flight.
    always_comb begin
        w_state_nxt = r_state;
        if (start) begin
            w_state_nxt = FIRST;
        end else begin
            case (r_state)
                IDLE:    w_state_nxt = IDLE;
                FIRST:   if (d_in_vld) w_state_nxt = w_hdr_bad ? ERR : ACC;
                ACC:     if (d_in_vld && w_last) w_state_nxt = FOLD;
                ERR:     w_state_nxt = IDLE;
                FOLD:    w_state_nxt = DONE;
                DONE:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_mode  <= GENERATE;
            r_ihl   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (start) begin
                r_mode <= csum_mode_t'(mode);
                r_cnt  <= '0;
            end else if (w_acc_en) begin
                r_cnt <= r_cnt + 4'd1;
                if (r_state == FIRST)
                    r_ihl <= d_in[DATA_W-5 -: 4];
            end
        end
    end

    assign w_crc_new = ~r_fold16_p1;

    // p1: folded sum; result registers load one cycle later from DONE or ERR.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fold16_p1 <= '0;
            r_crc       <= '0;
            r_crc_vld   <= 1'b0;
            r_crc_ok    <= 1'b0;
            r_hdr_err   <= 1'b0;
        end else begin
            r_crc_vld <= 1'b0;
            if (r_state == FOLD)
                r_fold16_p1 <= fold16(w_acc_p0);
            if (!start && r_state == ERR) begin
                r_crc_vld <= 1'b1;
                r_hdr_err <= 1'b1;
                r_crc_ok  <= 1'b0;
                r_crc     <= '0;
            end else if (!start && r_state == DONE) begin
                r_crc_vld <= 1'b1;
                r_hdr_err <= 1'b0;
                r_crc     <= w_crc_new;
                r_crc_ok  <= (r_mode == GENERATE) || (w_crc_new == 16'h0000);
            end
        end
    end

    assign crc     = r_crc;
    assign crc_vld = r_crc_vld;
    assign crc_ok  = r_crc_ok;
    assign hdr_err = r_hdr_err;
    assign busy    = (r_state != IDLE);
endmodule

// File: tb/tb_ip_v4_hdr_csum_engine.sv
// Bench for ip_v4_hdr_csum_engine: 32- and 64-bit instances against a checksum model and scoreboard.
module tb_ip_v4_hdr_csum_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start32, mode32, vld32;
    logic [31:0] d32;
    logic [15:0] crc32;
    logic        cv32, ok32, err32, busy32;
    logic        start64, mode64, vld64;
    logic [63:0] d64;
    logic [15:0] crc64;
    logic        cv64, ok64, err64, busy64;

    ip_v4_hdr_csum_engine #(.DATA_W(32)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .mode(mode32), .d_in(d32), .d_in_vld(vld32),
        .crc(crc32), .crc_vld(cv32), .crc_ok(ok32), .hdr_err(err32), .busy(busy32)
    );
    ip_v4_hdr_csum_engine #(.DATA_W(64)) dut64 (
        .clk(clk), .reset(reset), .start(start64), .mode(mode64), .d_in(d64), .d_in_vld(vld64),
        .crc(crc64), .crc_vld(cv64), .crc_ok(ok64), .hdr_err(err64), .busy(busy64)
    );

    typedef struct {
        int          cyc;
        logic [15:0] c;
        logic        ok;
        logic        err;
    } exp_t;

    exp_t        q32[$];
    exp_t        q64[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          pcnt[2];
    logic [15:0] pc[2];
    logic        pok[2];
    logic        perr[2];
    logic        held[2];
    logic [31:0] hw[16];
    logic [31:0] tw[8];
    int          ntrail = 0;
    logic [15:0] mc;
    logic        mok, merr;
    int          p;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Checksum straight from the RFC rules over the IHL words held in hw[].
    function automatic void model(input logic md, output logic [15:0] c, output logic ok,
                                  output logic err);
        int unsigned s;
        int          ihl;
        logic [15:0] h;
        ihl = int'(hw[0][27:24]);
        err = (hw[0][31:28] != 4'd4) || (ihl < 5);
        c   = 16'h0;
        ok  = 1'b0;
        if (!err) begin
            s = 0;
            for (int i = 0; i < 2 * ihl; i++) begin
                h = (i % 2 == 0) ? hw[i/2][31:16] : hw[i/2][15:0];
                if (md == 1'b0 && i == 5) h = 16'h0;
                s = s + 32'(h);
            end
            while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
            c  = ~s[15:0];
            ok = md ? (c == 16'h0) : 1'b1;
        end
    endfunction

    task automatic drive(input int sel, input logic st, input logic md, input logic [63:0] d,
                         input logic v);
        if (sel == 0) begin
            start32 = st; mode32 = md; d32 = d[63:32]; vld32 = v;
        end else begin
            start64 = st; mode64 = md; d64 = d; vld64 = v;
        end
        if (st) held[sel] = 1'b0;
    endtask

    // Streams hw[] as one header; abort_at>=0 stops after that many beats without a result.
    task automatic send_hdr(input int sel, input logic md, input int bub, input int abort_at);
        logic [15:0] c;
        logic        ok, err;
        int          nb, ihl;
        logic [31:0] lo;
        exp_t        e;
        model(md, c, ok, err);
        ihl = err ? 2 : int'(hw[0][27:24]);
        nb  = err ? 1 : ((sel == 0) ? ihl : (ihl + 1) / 2);
        @(posedge clk); #1;
        drive(sel, 1'b1, md, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        for (int b = 0; b < nb; b++) begin
            while (int'($urandom_range(0, 99)) < bub) begin
                @(posedge clk); #1;
                drive(sel, 1'b0, 1'($urandom), {$urandom, $urandom}, 1'b0);
            end
            @(posedge clk); #1;
            if (b == abort_at) begin
                drive(sel, 1'b0, 1'b0, 64'h0, 1'b0);
                return;
            end
            if (sel == 0) begin
                drive(sel, 1'b0, 1'($urandom), {hw[b], $urandom}, 1'b1);
            end else begin
                lo = (2 * b + 1 < ihl) ? hw[2*b+1] : $urandom;
                drive(sel, 1'b0, 1'($urandom), {hw[2*b], lo}, 1'b1);
            end
            if (b == nb - 1) begin
                e.cyc = cyc + (err ? 2 : 3);
                e.c = c; e.ok = ok; e.err = err;
                if (sel == 0) q32.push_back(e);
                else q64.push_back(e);
            end
        end
        for (int t = 0; t < ntrail; t++) begin
            @(posedge clk); #1;
            drive(sel, 1'b0, 1'($urandom), {tw[t], $urandom}, 1'b1);
        end
        @(posedge clk); #1;
        drive(sel, 1'b0, 1'b0, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cmp(input int sel, input logic v, input logic [15:0] c, input logic ok,
                       input logic er, input logic bz);
        exp_t e;
        logic have;
        have = 1'b0;
        if (sel == 0 && q32.size() > 0 && q32[0].cyc == cyc) begin e = q32.pop_front(); have = 1'b1; end
        if (sel == 1 && q64.size() > 0 && q64[0].cyc == cyc) begin e = q64.pop_front(); have = 1'b1; end
        chk($sformatf("crc_vld[%0d]", sel), 32'(v), 32'(have));
        if (v) begin
            pcnt[sel]++;
            pc[sel] = c; pok[sel] = ok; perr[sel] = er; held[sel] = 1'b1;
            if (have) begin
                chk($sformatf("crc[%0d]", sel), 32'(c), 32'(e.c));
                chk($sformatf("crc_ok[%0d]", sel), 32'(ok), 32'(e.ok));
                chk($sformatf("hdr_err[%0d]", sel), 32'(er), 32'(e.err));
                chk($sformatf("busy_at_pulse[%0d]", sel), 32'(bz), 32'h0);
            end
        end else if (held[sel]) begin
            chk($sformatf("hold[%0d]", sel), 32'({c, ok, er}), 32'({pc[sel], pok[sel], perr[sel]}));
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            cmp(0, cv32, crc32, ok32, err32, busy32);
            cmp(1, cv64, crc64, ok64, err64, busy64);
        end
    end

    task automatic set_t1();
        hw[0] = 32'h4500_0073; hw[1] = 32'h0000_4000; hw[2] = 32'h4011_0000;
        hw[3] = 32'hc0a8_0001; hw[4] = 32'hc0a8_00c7;
    endtask

    task automatic clear_held();
        for (int s = 0; s < 2; s++) begin
            held[s] = 1'b1; pc[s] = 16'h0; pok[s] = 1'b0; perr[s] = 1'b0;
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, " outs32"}, 32'({crc32, cv32, ok32, err32, busy32}), 32'h0);
        chk({nm, " outs64"}, 32'({crc64, cv64, ok64, err64, busy64}), 32'h0);
    endtask

    task automatic chk_last(input string nm, input int sel, input int p0, input logic [15:0] c,
                            input logic ok, input logic er);
        chk({nm, " pulses"}, 32'(pcnt[sel] - p0), 32'd1);
        chk({nm, " crc"}, 32'(pc[sel]), 32'(c));
        chk({nm, " ok/err"}, 32'({pok[sel], perr[sel]}), 32'({ok, er}));
    endtask

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int   sel, kind, ihl;
        logic md;
        held[0] = 1'b0; held[1] = 1'b0;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 64'h0, 1'b0);
        drive(1, 1'b0, 1'b0, 64'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        clear_held();

        // T1 generate, plus model pin
        set_t1();
        model(1'b0, mc, mok, merr);
        chk("model T1", 32'(mc), 32'hB861);
        p = pcnt[0]; send_hdr(0, 1'b0, 0, -1);
        chk_last("T1", 0, p, 16'hB861, 1'b1, 1'b0);

        // T2 verify with trailing payload words
        hw[2] = 32'h4011_b861;
        tw[0] = 32'h0035_e97c; tw[1] = 32'h005f_279f; tw[2] = 32'h1e4b_8180; ntrail = 3;
        p = pcnt[0]; send_hdr(0, 1'b1, 0, -1);
        chk_last("T2", 0, p, 16'h0000, 1'b1, 1'b0);
        chk("T2 busy after", 32'(busy32), 32'h0);
        ntrail = 0;

        // T3 corrupted verify
        hw[3] = 32'hc0a8_0002;
        model(1'b1, mc, mok, merr);
        chk("model T3", 32'(mc), 32'hFFFE);
        p = pcnt[0]; send_hdr(0, 1'b1, 0, -1);
        chk_last("T3", 0, p, 16'hFFFE, 1'b0, 1'b0);

        // T4 IHL=6 with bubbles, both widths
        set_t1(); hw[0] = 32'h4600_0073; hw[5] = 32'h0000_0000;
        model(1'b0, mc, mok, merr);
        chk("model T4", 32'(mc), 32'hB761);
        p = pcnt[0]; send_hdr(0, 1'b0, 40, -1);
        chk_last("T4/32", 0, p, 16'hB761, 1'b1, 1'b0);
        p = pcnt[1]; send_hdr(1, 1'b0, 40, -1);
        chk_last("T4/64", 1, p, 16'hB761, 1'b1, 1'b0);
        set_t1();
        p = pcnt[1]; send_hdr(1, 1'b0, 20, -1);
        chk_last("T1/64 odd", 1, p, 16'hB861, 1'b1, 1'b0);

        // T5 bad headers
        hw[0] = 32'h6500_0073;
        p = pcnt[0]; send_hdr(0, 1'b1, 0, -1);
        chk_last("T5 ver/32", 0, p, 16'h0000, 1'b0, 1'b1);
        p = pcnt[1]; send_hdr(1, 1'b0, 0, -1);
        chk_last("T5 ver/64", 1, p, 16'h0000, 1'b0, 1'b1);
        hw[0] = 32'h4200_0073;
        p = pcnt[0]; send_hdr(0, 1'b0, 0, -1);
        chk_last("T5 ihl/32", 0, p, 16'h0000, 1'b0, 1'b1);
        p = pcnt[1]; send_hdr(1, 1'b1, 0, -1);
        chk_last("T5 ihl/64", 1, p, 16'h0000, 1'b0, 1'b1);

        // T6 restart mid-header
        set_t1();
        p = pcnt[0]; send_hdr(0, 1'b0, 0, 3); send_hdr(0, 1'b0, 0, -1);
        chk_last("T6 restart/32", 0, p, 16'hB861, 1'b1, 1'b0);
        p = pcnt[1]; send_hdr(1, 1'b0, 0, 2); send_hdr(1, 1'b0, 0, -1);
        chk_last("T6 restart/64", 1, p, 16'hB861, 1'b1, 1'b0);

        // T6 async reset mid-header
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 64'h0, 1'b0);
        for (int b = 0; b < 2; b++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, {hw[b], 32'h0}, 1'b1);
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 64'h0, 1'b0);
        chk("T6 busy mid", 32'(busy32), 32'h1);
        #2;
        reset = 1'b1;
        clear_held();
        #1;
        chk_zero("T6 async reset");
        for (int b = 2; b < 5; b++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, {hw[b], 32'h0}, 1'b1);
        end
        @(negedge clk);
        reset = 1'b0;
        p = pcnt[0];
        for (int b = 0; b < 8; b++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, 1'b0, {hw[b % 5], 32'h0}, 1'b1);
        end
        drive(0, 1'b0, 1'b0, 64'h0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("T6 no pulse after reset", 32'(pcnt[0] - p), 32'h0);
        p = pcnt[0]; send_hdr(0, 1'b0, 0, -1);
        chk_last("T6 after reset", 0, p, 16'hB861, 1'b1, 1'b0);

        // Randomized headers on both widths
        for (int it = 0; it < 40; it++) begin
            sel  = int'($urandom_range(0, 1));
            md   = 1'($urandom);
            kind = int'($urandom_range(0, 9));
            ihl  = int'($urandom_range(5, 15));
            for (int w = 0; w < 16; w++) hw[w] = $urandom;
            hw[0][31:24] = {4'h4, 4'(ihl)};
            if (kind == 0) begin
                if ($urandom_range(0, 1) == 1) hw[0][31:28] = 4'($urandom_range(5, 15));
                else hw[0][27:24] = 4'($urandom_range(0, 4));
            end else if (md && $urandom_range(0, 1) == 1) begin
                model(1'b0, mc, mok, merr);
                hw[2][15:0] = mc;
            end
            ntrail = int'($urandom_range(0, 3));
            for (int t = 0; t < 8; t++) tw[t] = $urandom;
            if (kind == 1) send_hdr(sel, md, 30, int'($urandom_range(1, 3)));
            send_hdr(sel, md, 30, -1);
        end

        chk("scoreboard32 drained", 32'(q32.size()), 32'h0);
        chk("scoreboard64 drained", 32'(q64.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
